// File: rtl/bsg_chip_wh_loopback_arbiter_pkg.sv
// Shared wormhole definitions for the chip loopback path: default flit geometry,
// header layout, arbiter FSM states and the statistics counter width.
package bsg_chip_pkg;

  localparam int unsigned wh_flit_width_gp      = 16;
  localparam int unsigned wh_cord_width_gp      = 5;
  localparam int unsigned wh_len_width_gp       = 4;
  localparam int unsigned wh_arb_stats_width_gp = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } wh_arb_state_e;

  // Header occupies the low bits of a flit: cord at [cord-1:0], len just above it.
  typedef struct packed {
    logic [wh_len_width_gp-1:0]  len;
    logic [wh_cord_width_gp-1:0] cord;
  } wh_header_s;

endpackage

// File: rtl/bsg_chip_wh_loopback_arbiter_rr.sv
// Round-robin priority search: grants the first request at or above the pointer,
// wrapping; the pointer moves past the granted requester only when told to.
module bsg_arb_round_robin #(
  parameter int unsigned num_in_p = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [num_in_p-1:0] i_reqs,
  input  logic                i_update_v,
  input  logic [num_in_p-1:0] i_update_grant,
  output logic [num_in_p-1:0] o_grant
);

  localparam int unsigned ptr_w = (num_in_p > 1) ? $clog2(num_in_p) : 1;

  logic [ptr_w-1:0] r_ptr;
  logic [ptr_w-1:0] w_upd_idx;
  logic [ptr_w-1:0] w_ptr_next;
  int unsigned      w_idx;
  logic             w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 0; k < num_in_p; k++) begin
      w_idx = 32'(r_ptr) + k;
      if (w_idx >= num_in_p) w_idx = w_idx - num_in_p;
      if (!w_found && i_reqs[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

  always_comb begin
    w_upd_idx = '0;
    for (int unsigned k = 0; k < num_in_p; k++) begin
      if (i_update_grant[k]) w_upd_idx = ptr_w'(k);
    end
    w_ptr_next = (w_upd_idx == ptr_w'(num_in_p - 1)) ? '0 : w_upd_idx + ptr_w'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_update_v) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/bsg_chip_wh_loopback_arbiter.sv
// Wormhole loopback arbiter: one packet owns the output from header to last body flit,
// owners rotate round-robin. BSG_CHIP_WH_ARB_STATS_EN adds per-requester header counters.
module bsg_chip_wh_loopback_arbiter
  import bsg_chip_pkg::*;
#(
  parameter int unsigned num_in_p     = 4,
  parameter int unsigned flit_width_p = wh_flit_width_gp,
  parameter int unsigned cord_width_p = wh_cord_width_gp,
  parameter int unsigned len_width_p  = wh_len_width_gp
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic [num_in_p*flit_width_p-1:0]          data_i,
  input  logic [num_in_p-1:0]                       v_i,
  output logic [num_in_p-1:0]                       yumi_o,
  output logic [flit_width_p-1:0]                   data_o,
  output logic                                      v_o,
  input  logic                                      ready_and_i,
  output logic [num_in_p-1:0]                       grant_o,
  output logic                                      busy_o,
  output logic [num_in_p*wh_arb_stats_width_gp-1:0] stats_o
);

  wh_arb_state_e          r_state;
  wh_arb_state_e          w_state_next;
  logic [num_in_p-1:0]    r_owner;
  logic [num_in_p-1:0]    w_owner_next;
  logic [len_width_p-1:0] r_cnt;
  logic [len_width_p-1:0] w_cnt_next;
  logic [len_width_p-1:0] w_hdr_len;
  logic [num_in_p-1:0]    w_rr_grant;
  logic [num_in_p-1:0]    w_grant;
  logic                   w_hs;
  logic                   w_done;

  bsg_arb_round_robin #(
    .num_in_p(num_in_p)
  ) u_rr (
    .i_clk         (clk_i),
    .i_rst_n       (reset_n_i),
    .i_reqs        (v_i),
    .i_update_v    (w_done),
    .i_update_grant(w_grant),
    .o_grant       (w_rr_grant)
  );

  assign w_grant = (r_state == BUSY) ? r_owner : w_rr_grant;

  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < num_in_p; i++) begin
      if (w_grant[i]) data_o = data_i[i*flit_width_p +: flit_width_p];
    end
  end

  assign v_o       = |(v_i & w_grant);
  assign w_hs      = v_o & ready_and_i;
  assign yumi_o    = w_grant & {num_in_p{w_hs}};
  assign grant_o   = w_grant;
  assign busy_o    = (r_state == BUSY);
  assign w_hdr_len = data_o[cord_width_p +: len_width_p];

  // Packet completion (zero-length header or last body flit) always coincides with
  // w_grant being the finishing requester, so w_grant doubles as the pointer update.
  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_cnt_next   = r_cnt;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          if (w_hdr_len == '0) begin
            w_done = 1'b1;
          end else begin
            w_state_next = BUSY;
            w_owner_next = w_grant;
            w_cnt_next   = w_hdr_len;
          end
        end
      end
      BUSY: begin
        if (w_hs) begin
          w_cnt_next = r_cnt - len_width_p'(1);
          if (r_cnt == len_width_p'(1)) begin
            w_done       = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_cnt   <= w_cnt_next;
    end
  end

`ifdef BSG_CHIP_WH_ARB_STATS_EN
  logic [wh_arb_stats_width_gp-1:0] r_stats [num_in_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < num_in_p; i++) r_stats[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < num_in_p; i++) begin
        if ((r_state == IDLE) && w_hs && w_grant[i] && (r_stats[i] != '1)) begin
          r_stats[i] <= r_stats[i] + wh_arb_stats_width_gp'(1);
        end
      end
    end
  end

  always_comb begin
    stats_o = '0;
    for (int unsigned i = 0; i < num_in_p; i++) begin
      stats_o[i*wh_arb_stats_width_gp +: wh_arb_stats_width_gp] = r_stats[i];
    end
  end
`else
  assign stats_o = '0;
`endif

endmodule

// File: tb/tb_bsg_chip_wh_loopback_arbiter.sv
// Scoreboard bench for the wormhole loopback arbiter: a packet-level reference model
// predicts each cycle's owner and transferred flit; a monitor compares the DUT.
module tb_bsg_chip_wh_loopback_arbiter;
  import bsg_chip_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned FW = wh_flit_width_gp;
  localparam int unsigned CW = wh_cord_width_gp;
  localparam int unsigned LW = wh_len_width_gp;
  localparam int unsigned SW = wh_arb_stats_width_gp;

  typedef struct {
    bit             hs;
    logic [FW-1:0]  flit;
    logic [N-1:0]   grant;
    bit             busy;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N*FW-1:0] data_i = '0;
  logic [N-1:0]    v_i = '0;
  logic [N-1:0]    yumi_o;
  logic [FW-1:0]   data_o;
  logic            v_o;
  logic            ready = 1'b0;
  logic [N-1:0]    grant_o;
  logic            busy_o;
  logic [N*SW-1:0] stats_o;

  always #5 clk = ~clk;

  bsg_chip_wh_loopback_arbiter #(
    .num_in_p    (N),
    .flit_width_p(FW),
    .cord_width_p(CW),
    .len_width_p (LW)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .data_i     (data_i),
    .v_i        (v_i),
    .yumi_o     (yumi_o),
    .data_o     (data_o),
    .v_o        (v_o),
    .ready_and_i(ready),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .stats_o    (stats_o)
  );

  logic [FW-1:0] src_q [N][$];
  exp_t          exp_q [$];
  int unsigned   hdr_log [$];
  logic [N-1:0]  consumed = '0;
  int            checks = 0;
  int            errors = 0;

  // Reference model state: owner (-1 when no packet open), remaining body flits, pointer.
  int            m_owner = -1;
  int            m_left = 0;
  int            m_ptr = 0;
  int unsigned   m_hdrs [N];

  int unsigned   ready_mode = 0;
  bit            gap_en = 1'b0;
  int unsigned   cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_left  = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) m_hdrs[i] = 0;
  endtask

  task automatic model_cycle();
    exp_t e;
    int   g = -1;
    if (m_owner >= 0) g = m_owner;
    else begin
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (g < 0 && v_i[j]) g = j;
      end
    end
    e.grant = '0;
    if (g >= 0) e.grant[g] = 1'b1;
    e.busy = (m_owner >= 0);
    e.hs   = (g >= 0) && v_i[g] && ready;
    e.flit = e.hs ? src_q[g][0] : '0;
    if (e.hs) begin
      if (m_owner < 0) begin
        int len = int'(e.flit[CW +: LW]);
        m_hdrs[g]++;
        if (len == 0) m_ptr = (g + 1) % N;
        else begin
          m_owner = g;
          m_left  = len;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_owner = -1;
          m_ptr   = (g + 1) % N;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic add_pkt(input int i, input int unsigned len);
    wh_header_s    h;
    logic [FW-1:0] f;
    h.len  = LW'(len);
    h.cord = CW'($urandom);
    f = FW'($urandom);
    f[CW+LW-1:0] = h;
    src_q[i].push_back(f);
    for (int unsigned k = 0; k < len; k++) src_q[i].push_back(FW'($urandom));
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (consumed[i]) begin
        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
        v_i[i] = 1'b0;
      end
    end
    consumed = '0;
    for (int i = 0; i < N; i++) begin
      if (!v_i[i] && src_q[i].size() > 0 && (!gap_en || $urandom_range(3, 0) != 0)) v_i[i] = 1'b1;
      data_i[i*FW +: FW] = (src_q[i].size() > 0) ? src_q[i][0] : FW'($urandom);
    end
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = (cyc % 2 == 0);
      default: ready = ($urandom_range(2, 0) != 0);
    endcase
    model_cycle();
    cyc++;
  endtask

  task automatic run(input string name, input int unsigned max_cyc, output int unsigned used);
    int unsigned n = 0;
    bit          pending;
    cyc = 0;
    do begin
      step();
      n++;
      pending = 1'b0;
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) pending = 1'b1;
    end while (pending && n < max_cyc);
    chk({name, " undrained"}, 64'(pending), 64'(0));
    used = n - 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    v_i     = '0;
    ready   = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    consumed = '0;
    model_reset();
    @(negedge clk);
    hdr_log.delete();
    reset_n = 1'b1;
  endtask

  task automatic chk_order(input string name, input int unsigned exp[$]);
    chk({name, " hdr count"}, 64'(hdr_log.size()), 64'(exp.size()));
    for (int k = 0; k < exp.size() && k < hdr_log.size(); k++)
      chk($sformatf("%s hdr[%0d]", name, k), 64'(hdr_log[k]), 64'(exp[k]));
  endtask

  task automatic chk_stats(input string name, input int unsigned exp[N]);
    for (int i = 0; i < N; i++) begin
`ifdef BSG_CHIP_WH_ARB_STATS_EN
      chk($sformatf("%s stats[%0d]", name, i), 64'(stats_o[i*SW +: SW]), 64'(exp[i]));
`else
      chk($sformatf("%s stats[%0d]", name, i), 64'(stats_o[i*SW +: SW]), 64'(0));
`endif
    end
  endtask

  // Monitor: one scoreboard entry per stepped cycle, compared mid-cycle.
  logic [N-1:0] prev_v = '0;
  logic [N-1:0] prev_yumi = '0;
  logic         prev_rst_n = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    logic hs;
    #2;
    if (reset_n && prev_rst_n) begin
      for (int i = 0; i < N; i++)
        assert (!(prev_v[i] && !prev_yumi[i]) || v_i[i])
          else $error("protocol: v_i[%0d] dropped before consume", i);
    end
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      hs = v_o & ready;
      chk("grant", 64'(grant_o), 64'(e.grant));
      chk("busy", 64'(busy_o), 64'(e.busy));
      chk("handshake", 64'(hs), 64'(e.hs));
      chk("yumi", 64'(yumi_o), e.hs ? 64'(e.grant) : 64'(0));
      if (e.hs) chk("data", 64'(data_o), 64'(e.flit));
      if (hs && !busy_o)
        for (int i = 0; i < N; i++) if (yumi_o[i]) hdr_log.push_back(i);
      consumed = yumi_o;
    end
    prev_v     = v_i;
    prev_yumi  = yumi_o;
    prev_rst_n = reset_n;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned used;
    int unsigned ord[$];
    int unsigned st[N];
    int unsigned npkt;

    model_reset();
    // Reset-state checks: IDLE rule with pointer 0 applies while reset is held.
    #2;
    chk("rst busy", 64'(busy_o), 64'(0));
    chk("rst grant", 64'(grant_o), 64'(0));
    chk("rst v_o", 64'(v_o), 64'(0));
    chk("rst yumi", 64'(yumi_o), 64'(0));
    chk("rst stats", 64'(stats_o == '0), 64'(1));
    v_i = 4'b1010; ready = 1'b1;
    #1;
    chk("rst grant rr", 64'(grant_o), 64'(4'b0010));
    chk("rst yumi rr", 64'(yumi_o), 64'(4'b0010));
    v_i = '0; ready = 1'b0;
    do_reset();

    // Single packet, input 2, len 3.
    add_pkt(2, 3);
    run("single", 100, used);
    chk("single cycles", 64'(used), 64'(4));
    ord = '{2};
    chk_order("single", ord);

    // All four requesting len-1 packets; input 0 has a second one.
    do_reset();
    add_pkt(0, 1); add_pkt(0, 1); add_pkt(1, 1); add_pkt(2, 1); add_pkt(3, 1);
    run("all4", 100, used);
    chk("all4 cycles", 64'(used), 64'(10));
    ord = '{0, 1, 2, 3, 0};
    chk_order("all4", ord);

    // Input 1 len 5 under toggling ready, input 3 waiting.
    do_reset();
    ready_mode = 1;
    add_pkt(1, 5); add_pkt(3, 0);
    run("toggle", 100, used);
    chk("toggle cycles", 64'(used), 64'(13));
    ord = '{1, 3};
    chk_order("toggle", ord);
    ready_mode = 0;

    // Zero-length headers from inputs 0 and 3 together.
    do_reset();
    add_pkt(0, 0); add_pkt(3, 0);
    run("zlen", 100, used);
    chk("zlen cycles", 64'(used), 64'(2));
    ord = '{0, 3};
    chk_order("zlen", ord);

    // Reset after 2 of 6 flits, then a fresh packet.
    do_reset();
    add_pkt(2, 5);
    step(); step();
    @(negedge clk);
    reset_n = 1'b0; ready = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    v_i = 4'b0110; consumed = '0;
    model_reset();
    #2;
    chk("midrst busy", 64'(busy_o), 64'(0));
    chk("midrst grant", 64'(grant_o), 64'(4'b0010));
    chk("midrst yumi", 64'(yumi_o), 64'(0));
    @(negedge clk);
    v_i = '0; reset_n = 1'b1; hdr_log.delete();
    add_pkt(1, 2);
    run("postrst", 100, used);
    chk("postrst cycles", 64'(used), 64'(3));
    ord = '{1};
    chk_order("postrst", ord);

    // Randomized traffic with gaps, random ready, including a maximum-length packet.
    do_reset();
    gap_en = 1'b1; ready_mode = 2;
    npkt = 0;
    add_pkt(1, (1 << LW) - 1); npkt++;
    for (int p = 0; p < 150; p++) begin
      add_pkt(int'($urandom_range(N - 1, 0)), $urandom_range((1 << LW) - 1, 0));
      npkt++;
    end
    run("random", 40000, used);
    chk("random hdr count", 64'(hdr_log.size()), 64'(npkt));
    for (int i = 0; i < N; i++) st[i] = m_hdrs[i];
    chk_stats("random", st);
    gap_en = 1'b0; ready_mode = 0;

    // Ten packets from input 2 for the counters.
    do_reset();
    for (int p = 0; p < 10; p++) add_pkt(2, $urandom_range(3, 0));
    run("stats", 500, used);
    st = '{0, 0, 10, 0};
    chk_stats("stats", st);

    repeat (3) @(negedge clk);
    chk("scoreboard empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
